// File: rtl/load_store_unit.sv
// Sub-word load/store sequencer in front of a 16-byte big-endian word memory.
// Sub-word stores run as read-modify-write; loads are lane-extracted and extended.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [3:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [3:0]  mem_byte_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_e_read,
    output logic        mem_e_write,
    input  logic [31:0] mem_rdata
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned SIZE_W = 2;

    localparam logic [SIZE_W-1:0] SZ_BYTE = 2'b00;
    localparam logic [SIZE_W-1:0] SZ_HALF = 2'b01;
    localparam logic [SIZE_W-1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_e;

    state_e              state_q, state_d;
    logic                we_q;
    logic [SIZE_W-1:0]   size_q;
    logic                uns_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   merge_q;
    logic [DATA_W-1:0]   rdata_q;

    logic [1:0]          lane;
    logic [7:0]          byte_lane;
    logic [15:0]         half_lane;
    logic [DATA_W-1:0]   load_ext;
    logic [DATA_W-1:0]   merged;
    logic                err_cap;

    // Misaligned halfword/word or reserved size.
    function automatic logic is_err(input logic [SIZE_W-1:0] size, input logic [1:0] off);
        logic e;
        e = 1'b0;
        case (size)
            SZ_BYTE: e = 1'b0;
            SZ_HALF: e = off[0];
            SZ_WORD: e = (off != 2'b00);
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    assign lane    = addr_q[1:0];
    assign err_cap = is_err(size_q, addr_q[1:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (is_err(req_size, req_addr[1:0])) begin
                        state_d = S_RESP;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD:    state_d = we_q ? S_WR : S_RESP;
            S_WR:    state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Lane extraction from the word being read (big-endian: offset 0 is the MSB).
    always_comb begin
        byte_lane = 8'h00;
        case (lane)
            2'd0:    byte_lane = mem_rdata[31:24];
            2'd1:    byte_lane = mem_rdata[23:16];
            2'd2:    byte_lane = mem_rdata[15:8];
            default: byte_lane = mem_rdata[7:0];
        endcase
        half_lane = lane[1] ? mem_rdata[15:0] : mem_rdata[31:16];
        load_ext  = mem_rdata;
        case (size_q)
            SZ_BYTE: load_ext = uns_q ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            SZ_HALF: load_ext = uns_q ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
            default: load_ext = mem_rdata;
        endcase
    end

    // Store word: merged read data for sub-word, raw store data for word.
    always_comb begin
        merged = merge_q;
        case (size_q)
            SZ_BYTE: begin
                case (lane)
                    2'd0:    merged[31:24] = wdata_q[7:0];
                    2'd1:    merged[23:16] = wdata_q[7:0];
                    2'd2:    merged[15:8]  = wdata_q[7:0];
                    default: merged[7:0]   = wdata_q[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lane[1]) begin
                    merged[15:0] = wdata_q[15:0];
                end else begin
                    merged[31:16] = wdata_q[15:0];
                end
            end
            default: merged = wdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
        end else begin
            if ((state_q == S_IDLE) && req_valid) begin
                we_q    <= req_we;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state_q == S_RD) begin
                if (we_q) begin
                    merge_q <= mem_rdata;
                end else begin
                    rdata_q <= load_ext;
                end
            end
        end
    end

    // Outputs decoded only from the state register and captured fields.
    always_comb begin
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        rsp_rdata     = '0;
        rsp_err       = 1'b0;
        mem_byte_addr = '0;
        mem_wdata     = '0;
        mem_e_read    = 1'b0;
        mem_e_write   = 1'b0;
        case (state_q)
            S_IDLE: req_ready = 1'b1;
            S_RD: begin
                mem_e_read    = 1'b1;
                mem_byte_addr = {addr_q[3:2], 2'b00};
            end
            S_WR: begin
                mem_e_write   = 1'b1;
                mem_byte_addr = {addr_q[3:2], 2'b00};
                mem_wdata     = merged;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_cap;
                rsp_rdata = (we_q || err_cap) ? '0 : rdata_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory, transaction-level reference model,
// directed test-plan sequences with literal expectations, then randomized traffic.
module tb_load_store_unit;
    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [3:0]  mem_byte_addr;
    logic [31:0] mem_wdata;
    logic        mem_e_read;
    logic        mem_e_write;
    logic [31:0] mem_rdata;

    load_store_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .mem_byte_addr (mem_byte_addr),
        .mem_wdata     (mem_wdata),
        .mem_e_read    (mem_e_read),
        .mem_e_write   (mem_e_write),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Memory: combinational big-endian read, write committed at the end of e_write cycle.
    logic [7:0]  mem [16];
    int          wr_total;
    logic [31:0] last_wdata;

    assign mem_rdata = mem_e_read ? {mem[{mem_byte_addr[3:2], 2'd0}], mem[{mem_byte_addr[3:2], 2'd1}],
                                     mem[{mem_byte_addr[3:2], 2'd2}], mem[{mem_byte_addr[3:2], 2'd3}]}
                                  : 32'h0;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        wr_total   = 0;
        last_wdata = 32'h0;
        forever begin
            @(posedge clk);
            if (mem_e_write) begin
                for (int k = 0; k < 4; k++) mem[{mem_byte_addr[3:2], 2'(k)}] <= mem_wdata[31-8*k -: 8];
                wr_total++;
                last_wdata = mem_wdata;
            end
        end
    end

    // Reference model: one outstanding request, cycles-to-go counter, byte-array memory.
    logic [7:0]  ref_mem [16];
    int          cnt;
    bit          model_ok;
    logic        p_we, p_err;
    logic [1:0]  p_size;
    logic [3:0]  p_addr;
    logic [31:0] exp_rdata, exp_wword;

    task automatic model_accept();
        logic [7:0] t [16];
        logic [3:0] a, b;
        logic [7:0] v;
        logic [15:0] h;
        t = ref_mem;
        a = req_addr;
        b = {req_addr[3:2], 2'b00};
        p_we   = req_we;
        p_size = req_size;
        p_addr = req_addr;
        p_err  = (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0]) ||
                 (req_size == 2'd2 && req_addr[1:0] != 2'd0);
        exp_rdata = 32'h0;
        exp_wword = 32'h0;
        if (!p_err && !req_we) begin
            case (req_size)
                2'd0: begin
                    v = t[a];
                    exp_rdata = req_unsigned ? 32'(v) : 32'($signed(v));
                end
                2'd1: begin
                    h = {t[a], t[{a[3:1], 1'b1}]};
                    exp_rdata = req_unsigned ? 32'(h) : 32'($signed(h));
                end
                default: exp_rdata = {t[b], t[b | 4'd1], t[b | 4'd2], t[b | 4'd3]};
            endcase
        end
        if (!p_err && req_we) begin
            case (req_size)
                2'd0: t[a] = req_wdata[7:0];
                2'd1: begin
                    t[a] = req_wdata[15:8];
                    t[{a[3:1], 1'b1}] = req_wdata[7:0];
                end
                default: begin
                    t[b] = req_wdata[31:24];
                    t[b | 4'd1] = req_wdata[23:16];
                    t[b | 4'd2] = req_wdata[15:8];
                    t[b | 4'd3] = req_wdata[7:0];
                end
            endcase
            exp_wword = {t[b], t[b | 4'd1], t[b | 4'd2], t[b | 4'd3]};
        end
        if (p_err) cnt = 1;
        else if (req_we && req_size != 2'd2) cnt = 3;
        else cnt = 2;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'(i);
        cnt = 0; model_ok = 0;
        p_we = 0; p_err = 0; p_size = 0; p_addr = 0;
        exp_rdata = 0; exp_wword = 0;
        forever begin
            @(posedge clk);
            // A store commits at the end of its write cycle, even if reset arrives on that edge.
            if (model_ok && cnt == 2 && p_we && !p_err)
                for (int k = 0; k < 4; k++) ref_mem[{p_addr[3:2], 2'(k)}] = exp_wword[31-8*k -: 8];
            if (!rst_n) begin
                cnt = 0;
                model_ok = 1;
            end else if (model_ok) begin
                if (cnt == 0) begin
                    if (req_valid) model_accept();
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    logic       e_rd, e_wr, e_rsp;
    logic [3:0] e_base;
    always @(negedge clk) begin
        if (model_ok) begin
            e_rsp  = (cnt == 1);
            e_rd   = !p_err && ((!p_we && cnt == 2) || (p_we && p_size != 2'd2 && cnt == 3));
            e_wr   = !p_err && p_we && cnt == 2;
            e_base = {p_addr[3:2], 2'b00};
            check("req_ready", 32'(req_ready), 32'(cnt == 0));
            check("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
            check("rsp_err", 32'(rsp_err), 32'(e_rsp && p_err));
            check("rsp_rdata", rsp_rdata, (e_rsp && !p_we && !p_err) ? exp_rdata : 32'h0);
            check("mem_e_read", 32'(mem_e_read), 32'(e_rd));
            check("mem_e_write", 32'(mem_e_write), 32'(e_wr));
            check("mem_byte_addr", 32'(mem_byte_addr), (e_rd || e_wr) ? 32'(e_base) : 32'h0);
            if (e_wr) check("mem_wdata", mem_wdata, exp_wword);
            else if (cnt <= 1) check("mem_wdata_idle", mem_wdata, 32'h0);
        end
    end

    task automatic wait_rsp(output logic [31:0] rd, output logic er, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            req_valid = 1'b0;
        end while (!rsp_valid && lat < 10);
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_checks++;
            $display("FAIL accept_timeout: req_ready low for %0d cycles", n);
        end
    endtask

    task automatic send(input logic we, input logic [1:0] sz, input logic uns, input logic [3:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        wait_rsp(rd, er, lat);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat, w0, nedge;
    logic        rdy;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 4'd0; req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;

        send(1'b0, 2'd0, 1'b1, 4'd5, 32'h0, rd, er, lat);
        check("lbu5_data", rd, 32'h00000005);
        check("lbu5_lat", 32'(lat), 32'd2);

        w0 = wr_total;
        send(1'b1, 2'd0, 1'b0, 4'd6, 32'h80, rd, er, lat);
        check("sb6_lat", 32'(lat), 32'd3);
        check("sb6_writes", 32'(wr_total - w0), 32'd1);
        check("sb6_wdata", last_wdata, 32'h04058007);
        send(1'b0, 2'd0, 1'b0, 4'd6, 32'h0, rd, er, lat);
        check("lb6_data", rd, 32'hFFFFFF80);
        send(1'b0, 2'd2, 1'b0, 4'd4, 32'h0, rd, er, lat);
        check("lw4_data", rd, 32'h04058007);

        send(1'b1, 2'd1, 1'b0, 4'd10, 32'h1234BEEF, rd, er, lat);
        send(1'b0, 2'd2, 1'b0, 4'd8, 32'h0, rd, er, lat);
        check("lw8_data", rd, 32'h0809BEEF);
        send(1'b0, 2'd1, 1'b1, 4'd10, 32'h0, rd, er, lat);
        check("lhu10_data", rd, 32'h0000BEEF);
        send(1'b0, 2'd1, 1'b0, 4'd10, 32'h0, rd, er, lat);
        check("lh10_data", rd, 32'hFFFFBEEF);

        w0 = wr_total;
        send(1'b0, 2'd2, 1'b0, 4'd5, 32'h0, rd, er, lat);
        check("lw5_err", 32'(er), 32'd1);
        check("lw5_lat", 32'(lat), 32'd1);
        check("lw5_data", rd, 32'h0);
        send(1'b1, 2'd1, 1'b0, 4'd3, 32'h5555, rd, er, lat);
        check("sh3_err", 32'(er), 32'd1);
        check("sh3_lat", 32'(lat), 32'd1);
        send(1'b0, 2'd3, 1'b0, 4'd0, 32'h0, rd, er, lat);
        check("rsv_err", 32'(er), 32'd1);
        check("rsv_data", rd, 32'h0);
        check("err_no_write", 32'(wr_total - w0), 32'd0);

        // Reset during the read phase of a halfword store.
        w0 = wr_total;
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0; req_addr = 4'd0; req_wdata = 32'hAAAA;
        req_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_ready", 32'(req_ready), 32'd1);
        check("midrst_no_write", 32'(wr_total - w0), 32'd0);
        send(1'b0, 2'd2, 1'b0, 4'd0, 32'h0, rd, er, lat);
        check("lw0_data", rd, 32'h00010203);

        // Back-to-back with req_valid held high.
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 4'd12; req_wdata = 32'hDEADBEEF;
        req_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        req_we = 1'b0; req_wdata = 32'h0;
        nedge = 0;
        do begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            nedge++;
        end while (!rdy && nedge < 10);
        check("b2b_edges", 32'(nedge), 32'd3);
        wait_rsp(rd, er, lat);
        check("b2b_lw_data", rd, 32'hDEADBEEF);
        check("b2b_lw_lat", 32'(lat), 32'd2);

        // Randomized traffic, fields churn while busy, occasional resets.
        repeat (3000) begin
            @(negedge clk);
            rst_n        = ($urandom_range(0, 99) != 0);
            req_valid    = ($urandom_range(0, 2) != 0);
            req_we       = 1'($urandom_range(0, 1));
            req_size     = 2'($urandom_range(0, 3));
            req_unsigned = 1'($urandom_range(0, 1));
            req_addr     = 4'($urandom_range(0, 15));
            req_wdata    = $urandom;
        end
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 16; i++) check("final_mem", 32'(mem[i]), 32'(ref_mem[i]));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
